// File: rtl/quad_encoder_bank.sv
// Bank of NCH quadrature decoders: 2-FF sync, per-bit stability filter, x4 decode,
// windowed speed, sticky illegal-transition flags and a snapshot read port.
module quad_encoder_bank #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int FILT   = 4,
  parameter int PERIOD = 500000,
  parameter int AW     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   enc_a,
  input  logic [NCH-1:0]   enc_b,
  input  logic [NCH-1:0]   clr,
  input  logic             snap,
  input  logic             err_clr,
  input  logic [AW-1:0]    rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             tick
);
  // Filtered bit vector layout: [NCH-1:0] are the A inputs, [2*NCH-1:NCH] the B inputs.
  localparam int NB    = 2 * NCH;
  localparam int WIN_W = $clog2(PERIOD);
  localparam logic [7:0]       FILT_LAST  = 8'(FILT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(PERIOD - 1);
  localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]       PRIME_LOAD = 2'd2;
  localparam logic [1:0]       PRIME_DONE = 2'd3;

  logic [NB-1:0]    s1_q, s1_d, s2_q, s2_d;
  logic [NB-1:0]    filt_q, filt_d, prev_q, prev_d;
  logic [7:0]       fcnt_q [NB];
  logic [7:0]       fcnt_d [NB];
  logic [1:0]       prime_q, prime_d;
  logic             primed;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q [NCH];
  logic [CNT_W-1:0] count_d [NCH];
  logic [CNT_W-1:0] base_q [NCH];
  logic [CNT_W-1:0] base_d [NCH];
  logic [CNT_W-1:0] speed_q [NCH];
  logic [CNT_W-1:0] speed_d [NCH];
  logic [CNT_W-1:0] sh_count_q [NCH];
  logic [CNT_W-1:0] sh_count_d [NCH];
  logic [CNT_W-1:0] sh_speed_q [NCH];
  logic [CNT_W-1:0] sh_speed_d [NCH];
  logic [NCH-1:0]   err_q, err_d, err_set, sh_err_q, sh_err_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  assign primed  = (prime_q == PRIME_DONE);
  assign tick    = (win_q == WIN_LAST);
  assign rd_data = rd_data_q;

  // Sync, stability filter and post-reset priming.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    s1_d    = {enc_b, enc_a};
    s2_d    = s1_q;
    filt_d  = filt_q;
    prev_d  = filt_q;
    fcnt_d  = fcnt_q;
    prime_d = prime_q;
    if (!primed) begin
      prime_d = prime_q + 2'd1;
      // Adopt the settled input level without decoding it, so a resting 11 never counts.
      if (prime_q == PRIME_LOAD) begin
        filt_d = s2_q;
        prev_d = s2_q;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          fcnt_d[i] = '0;
        end else if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = s2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Decode, speed window and sticky errors; tick/snap read pre-update register values.
  always_comb begin
    count_d    = count_q;
    base_d     = base_q;
    speed_d    = speed_q;
    sh_count_d = sh_count_q;
    sh_speed_d = sh_speed_q;
    sh_err_d   = sh_err_q;
    err_set    = '0;
    win_d      = tick ? '0 : win_q + WIN_ONE;
    if (snap) begin
      sh_count_d = count_q;
      sh_speed_d = speed_q;
      sh_err_d   = err_q;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (tick) begin
        speed_d[ch] = count_q[ch] - base_q[ch];
        base_d[ch]  = count_q[ch];
      end
      if (primed) begin
        case ({prev_q[ch], prev_q[NCH+ch], filt_q[ch], filt_q[NCH+ch]})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: count_d[ch] = count_q[ch] + CNT_ONE;
          4'b0100, 4'b1101, 4'b1011, 4'b0010: count_d[ch] = count_q[ch] - CNT_ONE;
          4'b0011, 4'b1100, 4'b0110, 4'b1001: err_set[ch] = 1'b1;
          default: ;
        endcase
      end
      if (clr[ch]) begin
        count_d[ch] = '0;
        base_d[ch]  = '0;
      end
    end
    err_d = (err_clr ? '0 : err_q) | err_set;
  end

  always_comb begin
    rd_data_d = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (rd_addr == AW'(2 * ch))     rd_data_d = sh_count_q[ch];
      if (rd_addr == AW'(2 * ch + 1)) rd_data_d = sh_speed_q[ch];
    end
    if (rd_addr == AW'(NB)) rd_data_d = CNT_W'(sh_err_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      filt_q    <= '0;
      prev_q    <= '0;
      prime_q   <= '0;
      win_q     <= '0;
      err_q     <= '0;
      sh_err_q  <= '0;
      rd_data_q <= '0;
      // NOTE: the register arrays are architecturally visible through the read port, so they are reset too.
      for (int i = 0; i < NB; i++) fcnt_q[i] <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        count_q[ch]    <= '0;
        base_q[ch]     <= '0;
        speed_q[ch]    <= '0;
        sh_count_q[ch] <= '0;
        sh_speed_q[ch] <= '0;
      end
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      prime_q    <= prime_d;
      win_q      <= win_d;
      err_q      <= err_d;
      sh_err_q   <= sh_err_d;
      rd_data_q  <= rd_data_d;
      fcnt_q     <= fcnt_d;
      count_q    <= count_d;
      base_q     <= base_d;
      speed_q    <= speed_d;
      sh_count_q <= sh_count_d;
      sh_speed_q <= sh_speed_d;
    end
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: directed and random encoder activity against a
// transaction-level model (quadrature index arithmetic plus a latency queue).
module tb_quad_encoder_bank;
  localparam int NCH    = 4;
  localparam int CNT_W  = 8;
  localparam int FILT   = 4;
  localparam int PERIOD = 100;
  localparam int AW     = 8;
  // A raw change driven after edge n shows up in the count on edge n + LAT.
  localparam int LAT    = FILT + 3;

  typedef logic [CNT_W-1:0] word_t;
  typedef struct {
    int at;
    int ch;
    int delta;
    bit err;
  } ev_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] enc_a, enc_b, clr;
  logic           snap, err_clr;
  logic [AW-1:0]  rd_addr;
  word_t          rd_data;
  logic           tick;

  quad_encoder_bank #(
    .NCH(NCH), .CNT_W(CNT_W), .FILT(FILT), .PERIOD(PERIOD), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .snap(snap), .err_clr(err_clr), .rd_addr(rd_addr), .rd_data(rd_data), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model state.
  ev_t            pend[$];
  word_t          m_cnt [NCH];
  word_t          m_base [NCH];
  word_t          m_spd [NCH];
  word_t          m_sh_cnt [NCH];
  word_t          m_sh_spd [NCH];
  logic [NCH-1:0] m_err, m_sh_err;
  int             m_raw [NCH];
  int             m_win;
  int             edge_n;
  word_t          m_rd;
  int             total;
  int             bad;

  task automatic check(input string tag, input word_t got, input word_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic word_t m_read(input int a);
    if (a < 2 * NCH) return (a % 2 == 0) ? m_sh_cnt[a/2] : m_sh_spd[a/2];
    if (a == 2 * NCH) return word_t'(m_sh_err);
    return '0;
  endfunction

  function automatic logic [1:0] gray_ab(input int idx);
    case (idx & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_edge();
    logic [NCH-1:0] eset;
    edge_n++;
    eset = '0;
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_cnt[ch] = '0; m_base[ch] = '0; m_spd[ch] = '0;
        m_sh_cnt[ch] = '0; m_sh_spd[ch] = '0;
      end
      m_err = '0; m_sh_err = '0; m_win = 0; m_rd = '0;
      pend.delete();
    end else begin
      m_rd = m_read(int'(rd_addr));
      if (snap) begin
        m_sh_cnt = m_cnt; m_sh_spd = m_spd; m_sh_err = m_err;
      end
      if (m_win == PERIOD - 1)
        for (int ch = 0; ch < NCH; ch++) begin
          m_spd[ch]  = m_cnt[ch] - m_base[ch];
          m_base[ch] = m_cnt[ch];
        end
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].at == edge_n) begin
          if (pend[i].err) eset[pend[i].ch] = 1'b1;
          else m_cnt[pend[i].ch] = m_cnt[pend[i].ch] + word_t'(pend[i].delta);
          pend.delete(i);
        end
      if (err_clr) m_err = '0;
      m_err = m_err | eset;
      for (int ch = 0; ch < NCH; ch++)
        if (clr[ch]) begin
          m_cnt[ch] = '0; m_base[ch] = '0;
        end
      m_win = (m_win == PERIOD - 1) ? 0 : m_win + 1;
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rd_data", rd_data, m_rd);
    check("tick", word_t'(tick), word_t'(m_win == PERIOD - 1));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Move channel ch to quadrature index idx; counted changes are queued for the model.
  task automatic set_ab(input int ch, input int idx, input bit counted);
    int d;
    logic [1:0] ab;
    ev_t ev;
    d = (idx - m_raw[ch]) & 3;
    if (counted && d != 0) begin
      ev.at    = edge_n + LAT;
      ev.ch    = ch;
      ev.delta = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
      ev.err   = (d == 2);
      pend.push_back(ev);
    end
    m_raw[ch] = idx & 3;
    ab = gray_ab(idx);
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  task automatic step(input int ch, input int dir);
    set_ab(ch, (m_raw[ch] + dir + 4) & 3, 1'b1);
  endtask

  task automatic glitch(input int ch, input int width);
    int old;
    old = m_raw[ch];
    set_ab(ch, (old + 1) & 3, 1'b0);
    run(width);
    set_ab(ch, old, 1'b0);
  endtask

  task automatic snap_pulse();
    snap = 1'b1;
    cycle();
    snap = 1'b0;
  endtask

  task automatic read_exp(input int a, input word_t exp, input string tag);
    rd_addr = AW'(a);
    cycle();
    check(tag, rd_data, exp);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 2 * PERIOD) begin
      cycle();
      n++;
    end
    total++;
    assert (tick === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed tick=%b expected 1 within %0d cycles", tag, tick, 2 * PERIOD);
    end
  endtask

  initial begin
    int ch;
    int act;
    total = 0; bad = 0; edge_n = 0; m_win = 0;
    for (int i = 0; i < NCH; i++) m_raw[i] = 0;
    reset = 1'b1; enc_a = '0; enc_b = '0; clr = '0;
    snap = 1'b0; err_clr = 1'b0; rd_addr = '0;

    run(4);
    check("reset_rd_data", rd_data, '0);
    check("reset_tick", word_t'(tick), '0);
    reset = 1'b0;
    run(6);
    for (int a = 0; a <= 2 * NCH + 1; a++) read_exp(a, '0, $sformatf("reset_read_%0d", a));

    // Forward: 100 edges on ch0.
    for (int i = 0; i < 100; i++) begin
      step(0, 1);
      run(20);
    end
    snap_pulse();
    read_exp(0, 8'd100, "fwd_count0");
    read_exp(2, 8'd0, "fwd_count1");
    read_exp(4, 8'd0, "fwd_count2");
    read_exp(6, 8'd0, "fwd_count3");

    // Reverse below zero, then wrap past +127.
    for (int i = 0; i < 3; i++) begin
      step(1, -1);
      run(10);
    end
    snap_pulse();
    read_exp(2, 8'hFD, "rev_count1");
    clr = 4'b0010;
    cycle();
    clr = '0;
    for (int i = 0; i < 130; i++) begin
      step(1, 1);
      run(7);
    end
    run(10);
    snap_pulse();
    read_exp(2, 8'h82, "wrap_count1");

    // Glitch rejected, 5-cycle pulse accepted as +1 then -1.
    glitch(2, 3);
    run(10);
    snap_pulse();
    read_exp(4, 8'd0, "glitch_count2");
    set_ab(2, 1, 1'b1);
    run(5);
    set_ab(2, 0, 1'b1);
    run(2);
    snap_pulse();
    read_exp(4, 8'd1, "pulse_up_count2");
    run(10);
    snap_pulse();
    read_exp(4, 8'd0, "pulse_down_count2");

    // Illegal transitions and sticky error clearing.
    set_ab(3, 2, 1'b1);
    run(10);
    snap_pulse();
    read_exp(6, 8'd0, "illegal_count3");
    read_exp(2 * NCH, 8'h08, "illegal_err");
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    snap_pulse();
    read_exp(2 * NCH, 8'h00, "errclr_err");
    set_ab(3, 0, 1'b1);
    run(LAT - 1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    snap_pulse();
    read_exp(2 * NCH, 8'h08, "errclr_set_wins");

    // Speed over one window.
    wait_tick("tick_start");
    cycle();
    for (int i = 0; i < 10; i++) begin
      step(0, 1);
      run(7);
    end
    wait_tick("tick_end");
    cycle();
    snap_pulse();
    read_exp(1, 8'd10, "speed0");

    // clr and a decode step landing on the same edge.
    step(0, 1);
    run(LAT - 1);
    clr = 4'b0001;
    cycle();
    clr = '0;
    run(10);
    snap_pulse();
    read_exp(0, 8'd0, "clr_vs_step_count0");

    // Random activity; every cycle is compared against the model.
    for (int n = 0; n < 200; n++) begin
      ch  = $urandom_range(0, NCH - 1);
      act = $urandom_range(0, 9);
      if (act < 7) step(ch, ($urandom_range(0, 1) == 1) ? 1 : -1);
      else if (act < 9) glitch(ch, $urandom_range(1, FILT - 1));
      else set_ab(ch, (m_raw[ch] + 2) & 3, 1'b1);
      repeat ($urandom_range(6, 10)) begin
        rd_addr = AW'($urandom_range(0, 2 * NCH + 3));
        snap    = ($urandom_range(0, 7) == 0);
        err_clr = ($urandom_range(0, 15) == 0);
        clr     = '0;
        if ($urandom_range(0, 15) == 0) clr[$urandom_range(0, NCH - 1)] = 1'b1;
        cycle();
      end
      snap = 1'b0; err_clr = 1'b0; clr = '0;
    end
    run(LAT + 2);

    // Reset mid-sequence with inputs resting at 11 through release.
    step(0, 1);
    step(1, -1);
    run(2);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) set_ab(i, 2, 1'b0);
    cycle();
    check("midreset_rd_data", rd_data, '0);
    run(2);
    reset = 1'b0;
    run(50);
    snap_pulse();
    for (int a = 0; a <= 2 * NCH; a++) read_exp(a, '0, $sformatf("prime_read_%0d", a));
    step(0, 1);
    run(10);
    snap_pulse();
    read_exp(0, 8'd1, "after_prime_count0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
